// File: rtl/aemb2_dwbif_pkg.sv
// Shared encodings for the aeMB2 data-bus interface: access sizes, bus FSM states
// and the byte-lane helper used by the lane decoder.
package aemb2_dwbif_pkg;

    // Access size as presented by the execute stage; 2'b11 behaves as a word.
    typedef enum logic [1:0] {
        SizByte  = 2'b00,
        SizHalf  = 2'b01,
        SizWord  = 2'b10,
        SizWordX = 2'b11
    } siz_e;

    // Bus cycle state: IDLE waits for a request, BUSY waits for the slave ack.
    typedef enum logic {
        StIdle = 1'b0,
        StBusy = 1'b1
    } dwb_state_e;

    // Big-endian byte lane: address 0 maps to the most significant lane.
    function automatic logic [3:0] byte_lane(input logic [1:0] adr);
        logic [3:0] lane;
        unique case (adr)
            2'b00:   lane = 4'b1000;
            2'b01:   lane = 4'b0100;
            2'b10:   lane = 4'b0010;
            default: lane = 4'b0001;
        endcase
        return lane;
    endfunction

endpackage

// File: rtl/aemb2_dwbsel.sv
// Combinational lane decode and store-data replication for the data bus.
module aemb2_dwbsel
    import aemb2_dwbif_pkg::*;
(
    input  logic [1:0]  siz_i,
    input  logic [1:0]  adr_i,
    input  logic [31:0] opd_i,
    output logic [3:0]  sel_o,
    output logic [31:0] dat_o
);

    // Replicate right-justified store data across every lane so the slave can pick
    // whichever lanes sel_o enables without any further steering.
    always_comb begin
        sel_o = 4'b1111;
        dat_o = opd_i;
        unique case (siz_e'(siz_i))
            SizByte: begin
                sel_o = byte_lane(adr_i);
                dat_o = {4{opd_i[7:0]}};
            end
            SizHalf: begin
                // adr_i[0] is deliberately ignored for halfword accesses.
                sel_o = adr_i[1] ? 4'b0011 : 4'b1100;
                dat_o = {2{opd_i[15:0]}};
            end
            default: begin
                sel_o = 4'b1111;
                dat_o = opd_i;
            end
        endcase
    end

endmodule

// File: rtl/aemb2_dwbif.sv
// aeMB2 data Wishbone master: accepts one load/store from execute, runs a single
// registered bus cycle, stalls the pipeline until ack and captures the load word.
module aemb2_dwbif
    import aemb2_dwbif_pkg::*;
#(
    parameter int unsigned AEMB_HTX = 1
) (
    input  logic        gclk,
    input  logic        grst,
    input  logic        dena,
    input  logic        gpha,

    input  logic        mem_ex,
    input  logic        wre_ex,
    input  logic [1:0]  siz_ex,
    input  logic [31:0] adr_ex,
    input  logic [31:0] opd_ex,

    output logic [31:2] dwb_adr_o,
    output logic [3:0]  dwb_sel_o,
    output logic [31:0] dwb_dat_o,
    output logic        dwb_wre_o,
    output logic        dwb_stb_o,
    output logic        dwb_cyc_o,
    output logic        dwb_tag_o,
    input  logic [31:0] dwb_dat_i,
    input  logic        dwb_ack_i,

    output logic [31:0] dwb_mx,
    output logic [3:0]  sel_mx,
    output logic        dwb_stall
);

    localparam logic HtxEn = (AEMB_HTX != 0);

    dwb_state_e  state_q;
    logic [3:0]  sel_ex;
    logic [31:0] dat_ex;
    logic        accept;
    logic        finish;

    aemb2_dwbsel u_dwbsel (
        .siz_i (siz_ex),
        .adr_i (adr_ex[1:0]),
        .opd_i (opd_ex),
        .sel_o (sel_ex),
        .dat_o (dat_ex)
    );

    // A request is only taken from IDLE, so the completing edge can never start
    // the next cycle and back-to-back accesses always see one IDLE cycle.
    always_comb begin
        accept = (state_q == StIdle) && dena && mem_ex;
        finish = (state_q == StBusy) && dwb_ack_i;
    end

    // Bus FSM with all bus outputs, stall and load capture registered alongside state.
    always_ff @(posedge gclk) begin
        if (grst) begin
            state_q   <= StIdle;
            dwb_adr_o <= '0;
            dwb_sel_o <= '0;
            dwb_dat_o <= '0;
            dwb_wre_o <= 1'b0;
            dwb_stb_o <= 1'b0;
            dwb_cyc_o <= 1'b0;
            dwb_tag_o <= 1'b0;
            dwb_mx    <= '0;
            sel_mx    <= '0;
            dwb_stall <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        state_q   <= StBusy;
                        dwb_adr_o <= adr_ex[31:2];
                        dwb_sel_o <= sel_ex;
                        dwb_dat_o <= dat_ex;
                        dwb_wre_o <= wre_ex;
                        dwb_tag_o <= gpha & HtxEn;
                        dwb_stb_o <= 1'b1;
                        dwb_cyc_o <= 1'b1;
                        dwb_stall <= 1'b1;
                    end
                end
                StBusy: begin
                    if (finish) begin
                        state_q   <= StIdle;
                        dwb_stb_o <= 1'b0;
                        dwb_cyc_o <= 1'b0;
                        dwb_stall <= 1'b0;
                        sel_mx    <= dwb_sel_o;
                        // Stores leave the last load word in place.
                        if (!dwb_wre_o) begin
                            dwb_mx <= dwb_dat_i;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: doc/aemb2_dwbif.md
AEMB2_DWBIF -- requirements
Module: aeMB2_dwbif

Interface
REQ-001 SHALL have parameter AEMB_HTX, default 1, meaning hyperthreading enabled; when 1, dwb_tag_o carries the thread phase.
REQ-002 SHALL have port gclk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port grst, input, 1, reset, synchronous and active-high.
REQ-004 SHALL have port dena, input, 1, pipeline advance enable.
REQ-005 SHALL have port gpha, input, 1, current thread phase.
REQ-006 SHALL have port mem_ex, input, 1, load/store request valid from execute.
REQ-007 SHALL have port wre_ex, input, 1, 1 = store, 0 = load.
REQ-008 SHALL have port siz_ex, input, 2, access size: 00 byte, 01 half, 10 word, 11 treated as word.
REQ-009 SHALL have port adr_ex, input, 32, effective byte address.
REQ-010 SHALL have port opd_ex, input, 32, store data, right-justified.
REQ-011 SHALL have Wishbone master ports: dwb_adr_o out [31:2], dwb_sel_o out 4, dwb_dat_o out 32, dwb_wre_o out 1, dwb_stb_o out 1, dwb_cyc_o out 1, dwb_tag_o out 1, dwb_dat_i in 32, dwb_ack_i in 1.
REQ-012 SHALL have port dwb_mx, output, 32, captured raw load word for the register file.
REQ-013 SHALL have port sel_mx, output, 4, byte lanes of the completed access.
REQ-014 SHALL have port dwb_stall, output, 1, high while a bus cycle is outstanding.

Function
REQ-015 SHALL implement states IDLE and BUSY; IDLE->BUSY on rising edge with dena=1, mem_ex=1 in IDLE; BUSY->IDLE on edge with dwb_ack_i=1.
REQ-016 SHALL ignore mem_ex while BUSY and whenever dena=0.
REQ-017 SHALL, on acceptance, register dwb_adr_o=adr_ex[31:2], dwb_wre_o=wre_ex, dwb_tag_o=gpha (0 when AEMB_HTX=0), stb=cyc=1, visible in the cycle after the accepting edge.
REQ-018 SHALL compute big-endian lanes: byte adr[1:0] 00/01/10/11 -> 1000/0100/0010/0001; half adr[1] 0/1 -> 1100/0011 (adr[0] ignored); word -> 1111 (adr[1:0] ignored).
REQ-019 SHALL drive dwb_dat_o as {4{opd[7:0]}} byte, {2{opd[15:0]}} half, opd word; value held constant for the whole cycle.
REQ-020 SHALL hold all dwb_*_o stable while BUSY and ack=0.
REQ-021 SHALL, on edge with BUSY and ack=1, deassert stb/cyc, capture dwb_dat_i into dwb_mx (loads only; stores leave dwb_mx unchanged), and copy dwb_sel_o into sel_mx.
REQ-022 SHALL drive dwb_stall = 1 exactly while BUSY (registered with state); zero-wait-state ack yields stall for one cycle.
REQ-023 SHALL ignore dwb_ack_i while IDLE.
REQ-024 SHALL NOT start a new cycle on the same edge that completes one; back-to-back accesses have at least one IDLE cycle between stb pulses.

Reset
REQ-025 SHALL, on edge with grst=1, force IDLE, stb=cyc=wre=0, dwb_adr_o=0, dwb_sel_o=0, dwb_dat_o=0, dwb_tag_o=0, dwb_mx=0, sel_mx=0, dwb_stall=0.
REQ-026 SHALL abort an outstanding cycle when grst asserts mid-BUSY, dropping cyc/stb after that edge and discarding any coincident ack.
REQ-027 SHALL give grst priority over ack and mem_ex.

Structure
REQ-028 SHALL place size encodings (byte/half/word) and state encodings in the shared aeMB2 package.
REQ-029 SHALL factor lane decode and store replication (REQ-018/019) into combinational sub-module aeMB2_dwbsel.

Verification
REQ-030 SHALL cover: load word adr 0x00001004, ack after 3 cycles, dwb_dat_i=0xDEADBEEF -> sel 1111, adr_o 0x401, stall 4 cycles, dwb_mx=0xDEADBEEF, sel_mx=1111.
REQ-031 SHALL cover: store byte adr 0x0000000A, opd=0x12345678, zero-wait ack -> sel 0010, dat_o 0x78787878, wre 1, stall 1 cycle, dwb_mx unchanged.
REQ-032 SHALL cover: load half adr 0x00000003 -> sel 0011; store half opd 0x0000ABCD -> dat_o 0xABCDABCD.
REQ-033 SHALL cover: grst asserted on same edge as ack in BUSY -> IDLE, cyc/stb 0, dwb_mx=0, stall 0.
REQ-034 SHALL cover: mem_ex held high across back-to-back requests with dena=1 -> one IDLE cycle between stb pulses; spurious ack in IDLE -> no state change.
REQ-035 SHALL cover: gpha=1 at acceptance with AEMB_HTX=1 -> dwb_tag_o=1 for whole cycle; AEMB_HTX=0 -> dwb_tag_o=0.
